// File: rtl/hsi_pkg.sv
// hsi_pkg: shared types and constants for the HSI byte coder; HSI_CD_PARITY_EN selects 9-bit frames
package hsi_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_GAP} state_t;
    localparam logic MAN_ONE_FIRST  = 1'b1;
    localparam logic MAN_ZERO_FIRST = 1'b0;
    localparam int HSI_CD_HALF_BIT_CLKS = 4;
    localparam int HSI_CD_GAP_BITS      = 1;
`ifdef HSI_CD_PARITY_EN
    localparam int HSI_CD_NBITS = 9;
`else
    localparam int HSI_CD_NBITS = 8;
`endif
    function automatic logic man_first(input logic b);
        return b ? MAN_ONE_FIRST : MAN_ZERO_FIRST;
    endfunction
endpackage

// File: rtl/hsi_half_bit_timer.sv
// hsi_half_bit_timer: ticks on the last cycle of every HALF_BIT_CLKS-cycle half-bit
module hsi_half_bit_timer import hsi_pkg::*; #(
    parameter int HALF_BIT_CLKS = HSI_CD_HALF_BIT_CLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);
    logic [7:0] r_cnt;
    assign o_tick = r_cnt == 8'(HALF_BIT_CLKS - 1);
    // free-running modulo counter, realigned on every capture
    always_ff @(posedge clk) begin
        if (rst || i_restart) r_cnt <= 8'd0;
        else r_cnt <= o_tick ? 8'd0 : r_cnt + 8'd1;
    end
endmodule

// File: rtl/hsi_byte_coder.sv
// hsi_byte_coder: Manchester byte serialiser with inter-byte gap; HSI_CD_PARITY_EN adds an odd-parity bit
module hsi_byte_coder import hsi_pkg::*; #(
    parameter int HALF_BIT_CLKS = HSI_CD_HALF_BIT_CLKS,
    parameter int GAP_BITS      = HSI_CD_GAP_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       d_rdy,
    output logic       busy,
    output logic       tx,
    output logic       tx_en,
    output logic       byte_done
);
    localparam int NB = HSI_CD_NBITS;
    localparam logic [3:0] LAST_BIT = 4'(NB - 1);
    localparam logic [4:0] LAST_GAP = 5'(2 * GAP_BITS - 1);
    state_t          r_state;
    logic [NB-1:0]   r_sh;
    logic [NB-1:0]   w_load;
    logic [3:0]      r_bit;
    logic [4:0]      r_gap;
    logic            r_half;
    logic            w_tick;
    logic            w_cap;
`ifdef HSI_CD_PARITY_EN
    assign w_load = {d, ~^d};
`else
    assign w_load = d;
`endif
    assign w_cap = r_state == ST_IDLE && d_rdy;
    hsi_half_bit_timer #(.HALF_BIT_CLKS(HALF_BIT_CLKS)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_cap),
        .o_tick    (w_tick)
    );
    // frame sequencer: first half-bit is driven on the capture edge so all outputs stay registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sh      <= '0;
            r_bit     <= 4'd0;
            r_gap     <= 5'd0;
            r_half    <= 1'b0;
            busy      <= 1'b0;
            tx        <= 1'b0;
            tx_en     <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (d_rdy) begin
                    r_sh    <= w_load;
                    r_bit   <= 4'd0;
                    r_half  <= 1'b0;
                    r_state <= ST_DATA;
                    busy    <= 1'b1;
                    tx_en   <= 1'b1;
                    tx      <= man_first(w_load[NB-1]);
                end
                ST_DATA: if (w_tick) begin
                    if (!r_half) begin
                        r_half <= 1'b1;
                        tx     <= ~tx;
                    end else if (r_bit != LAST_BIT) begin
                        r_half <= 1'b0;
                        r_bit  <= r_bit + 4'd1;
                        r_sh   <= r_sh << 1;
                        tx     <= man_first(r_sh[NB-2]);
                    end else begin
                        tx    <= 1'b0;
                        tx_en <= 1'b0;
                        r_gap <= 5'd0;
                        r_sh  <= '0;
                        if (GAP_BITS == 0) begin
                            r_state   <= ST_IDLE;
                            busy      <= 1'b0;
                            byte_done <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: if (w_tick) begin
                    r_gap <= r_gap + 5'd1;
                    if (r_gap == LAST_GAP) begin
                        r_state   <= ST_IDLE;
                        busy      <= 1'b0;
                        byte_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hsi_byte_coder.sv
// tb_hsi_byte_coder: randomized bench with a per-byte waveform reference model for two parameter sets
module tb_hsi_byte_coder;
    typedef logic [3:0] exp_q_t [$];
`ifdef HSI_CD_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int H0 = 4, G0 = 1, H1 = 1, G1 = 0;
    localparam int L0 = (NB + G0) * 2 * H0;
    localparam int L1 = (NB + G1) * 2 * H1;
    logic clk = 1'b0, rst = 1'b1, d_rdy = 1'b0;
    logic [7:0] d = 8'h00;
    logic busy0, tx0, tx_en0, bd0, busy1, tx1, tx_en1, bd1;
    int checks = 0, failures = 0;
    int hh[2], gg[2];
    exp_q_t q[2];
    logic [3:0] e0, e1;
    int cb0, ce0, cd0, cl0, cb1;

    hsi_byte_coder #(.HALF_BIT_CLKS(H0), .GAP_BITS(G0)) u_dut (
        .clk(clk), .rst(rst), .d(d), .d_rdy(d_rdy),
        .busy(busy0), .tx(tx0), .tx_en(tx_en0), .byte_done(bd0)
    );
    hsi_byte_coder #(.HALF_BIT_CLKS(H1), .GAP_BITS(G1)) u_fast (
        .clk(clk), .rst(rst), .d(d), .d_rdy(d_rdy),
        .busy(busy1), .tx(tx1), .tx_en(tx_en1), .byte_done(bd1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // expected {tx, tx_en, busy, byte_done} per cycle from the capture edge onward
    function automatic exp_q_t gen(input logic [7:0] b, input int h, input int g);
        exp_q_t r;
        int ones = 0;
        logic bitv;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        for (int i = 0; i < NB; i++) begin
            bitv = (i < 8) ? b[7-i] : (ones % 2 == 0);
            for (int hf = 0; hf < 2; hf++)
                for (int c = 0; c < h; c++) r.push_back({bitv ^ (hf == 1), 1'b1, 1'b1, 1'b0});
        end
        for (int c = 0; c < g * 2 * h; c++) r.push_back(4'b0010);
        r.push_back(4'b0001);
        return r;
    endfunction

    task automatic step(input int k, output logic [3:0] e);
        if (rst) begin
            q[k].delete();
            e = 4'b0;
        end else begin
            if (q[k].size() == 0 && d_rdy) q[k] = gen(d, hh[k], gg[k]);
            e = (q[k].size() != 0) ? q[k].pop_front() : 4'b0;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        step(0, e0);
        step(1, e1);
        #1;
        check({tag, "_slow"}, {tx0, tx_en0, busy0, bd0}, e0);
        check({tag, "_fast"}, {tx1, tx_en1, busy1, bd1}, e1);
        cb0 += int'(busy0);
        ce0 += int'(tx_en0);
        cd0 += int'(bd0);
        cl0 += int'(!busy0);
        cb1 += int'(busy1);
    endtask

    task automatic clr();
        cb0 = 0; ce0 = 0; cd0 = 0; cl0 = 0; cb1 = 0;
    endtask

    initial begin
        hh[0] = H0; gg[0] = G0; hh[1] = H1; gg[1] = G1;
        clr();
        repeat (3) cyc("reset");
        rst = 1'b0;
        clr();
        repeat (10) cyc("idle");
        check("idle_busy", 32'(cb0 + cb1 + cd0), 32'd0);

        d = 8'hA5; d_rdy = 1'b1; clr();
        cyc("a5");
        d_rdy = 1'b0; d = 8'($urandom);
        repeat (L0 + 10) cyc("a5");
        check("a5_busy_len", 32'(cb0), 32'(L0));
        check("a5_txen_len", 32'(ce0), 32'(NB * 2 * H0));
        check("a5_done_cnt", 32'(cd0), 32'd1);
        check("fast_busy_len", 32'(cb1), 32'(L1));

        repeat (L0) cyc("settle");
        d = 8'h00; d_rdy = 1'b1; clr();
        cyc("b2b");
        d = 8'hFF;
        repeat (2 * L0) cyc("b2b");
        check("b2b_low_cycles", 32'(cl0), 32'd1);
        check("b2b_done_cnt", 32'(cd0), 32'd1);
        d_rdy = 1'b0;
        repeat (L0 + 5) cyc("drain");

        d = 8'($urandom); d_rdy = 1'b1;
        cyc("mid");
        d_rdy = 1'b0;
        repeat (19) cyc("mid");
        rst = 1'b1;
        cyc("mid_rst");
        check("mid_rst_outs", {busy0, tx0, tx_en0, bd0}, 4'b0);
        rst = 1'b0; clr();
        repeat (10) cyc("post_rst");
        check("post_rst_quiet", 32'(cb0 + cd0), 32'd0);
        d = 8'($urandom); d_rdy = 1'b1; clr();
        cyc("fresh");
        d_rdy = 1'b0;
        repeat (L0 + 3) cyc("fresh");
        check("fresh_busy_len", 32'(cb0), 32'(L0));
        check("fresh_done_cnt", 32'(cd0), 32'd1);

        repeat (2000) begin
            rst = ($urandom_range(299) == 0);
            d_rdy = ($urandom_range(3) == 0);
            d = 8'($urandom);
            cyc("rand");
        end
        rst = 1'b0; d_rdy = 1'b0;
        repeat (L0 + 5) cyc("end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
